mem_line_arbiter: RTL and testbench

Two-client arbiter that shares one line-granular main memory between two caches, typically the I-cache (client 0) and the D-cache (client 1).
- Each client keeps its existing swap-in/swap-out handshake: hold `rd_req` or `wr_req` until `gnt`, then drop.
- The arbiter selects one owner, forwards the owner's request to memory, and routes the memory's one-cycle `gnt` back to that owner.
- It latches read lines so the client can consume them one cycle after `gnt`.
- Fairness is round-robin.

---
 rtl/mem_line_arbiter.sv | 118 +++++++++++
 tb/tb_mem_line_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_arbiter.sv
// Round-robin arbiter sharing one line-granular main memory between two cache clients.
// The owner's request is forwarded combinationally; read lines are captured on the memory gnt.
module mem_line_arbiter #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 9,
    localparam int LINE_W       = 32 << LINE_ADDR_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                c0_rd_req,
    input  logic                c0_wr_req,
    input  logic [ADDR_LEN-1:0] c0_addr,
    input  logic [LINE_W-1:0]   c0_wr_line,
    output logic                c0_gnt,
    input  logic                c1_rd_req,
    input  logic                c1_wr_req,
    input  logic [ADDR_LEN-1:0] c1_addr,
    input  logic [LINE_W-1:0]   c1_wr_line,
    output logic                c1_gnt,
    output logic [LINE_W-1:0]   rd_line,
    output logic                mem_rd_req,
    output logic                mem_wr_req,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [LINE_W-1:0]   mem_wr_line,
    input  logic                mem_gnt,
    input  logic [LINE_W-1:0]   mem_rd_line,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                prio_q, prio_d;
    logic [LINE_W-1:0]   rd_line_q, rd_line_d;

    logic                req0, req1;
    logic                own_rd, own_wr;
    logic [ADDR_LEN-1:0] own_addr;
    logic [LINE_W-1:0]   own_wr_line;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            prio_q    <= 1'b0;
            rd_line_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            prio_q    <= prio_d;
            rd_line_q <= rd_line_d;
        end
    end

    always_comb begin
        req0        = c0_rd_req | c0_wr_req;
        req1        = c1_rd_req | c1_wr_req;
        own_rd      = owner_q ? c1_rd_req  : c0_rd_req;
        own_wr      = owner_q ? c1_wr_req  : c0_wr_req;
        own_addr    = owner_q ? c1_addr    : c0_addr;
        own_wr_line = owner_q ? c1_wr_line : c0_wr_line;

        state_d     = state_q;
        owner_d     = owner_q;
        prio_d      = prio_q;
        rd_line_d   = rd_line_q;
        mem_rd_req  = 1'b0;
        mem_wr_req  = 1'b0;
        mem_addr    = '0;
        mem_wr_line = '0;
        c0_gnt      = 1'b0;
        c1_gnt      = 1'b0;
        busy        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    owner_d = (req0 && req1) ? prio_q : req1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                busy        = 1'b1;
                // A write wins when the owner raises both request lines.
                mem_wr_req  = own_wr;
                mem_rd_req  = own_rd & ~own_wr;
                mem_addr    = own_addr;
                mem_wr_line = own_wr_line;
                if (mem_gnt) begin
                    c0_gnt  = ~owner_q;
                    c1_gnt  = owner_q;
                    if (own_rd && !own_wr) begin
                        rd_line_d = mem_rd_line;
                    end
                    prio_d  = ~owner_q;
                    state_d = ST_GAP;
                end else if (!own_rd && !own_wr) begin
                    // Owner withdrew: release without a gnt and keep the priority.
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rd_line = rd_line_q;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Bench for mem_line_arbiter: directed scenarios plus random two-client traffic
// checked against a transaction-level memory and round-robin model.
module tb_mem_line_arbiter;

    localparam int LW = 256;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          c0_rd_req, c0_wr_req, c1_rd_req, c1_wr_req;
    logic [AW-1:0] c0_addr, c1_addr;
    logic [LW-1:0] c0_wr_line, c1_wr_line;
    logic          c0_gnt, c1_gnt;
    logic [LW-1:0] rd_line;
    logic          mem_rd_req, mem_wr_req;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wr_line;
    logic          mem_gnt;
    logic [LW-1:0] mem_rd_line;
    logic          busy;

    int n_pass  = 0;
    int n_total = 0;
    logic [LW-1:0] last_rd;
    logic [LW-1:0] mem_arr [logic [AW-1:0]];

    localparam logic [LW-1:0] L1   = {8{32'h1111_1111}};
    localparam logic [LW-1:0] L2   = {8{32'h2222_2222}};
    localparam logic [LW-1:0] L3   = {8{32'h3333_3333}};
    localparam logic [LW-1:0] L5   = {8{32'h5555_0005}};
    localparam logic [LW-1:0] L6   = {8{32'h6666_0006}};
    localparam logic [LW-1:0] L8   = {8{32'h8888_0008}};
    localparam logic [LW-1:0] L9   = {8{32'h9999_0009}};
    localparam logic [LW-1:0] PA   = {8{32'hAAAA_5555}};
    localparam logic [LW-1:0] PB   = {8{32'hBBBB_4444}};
    localparam logic [LW-1:0] JUNK = {8{32'hDEAD_BEEF}};

    always #5 clk = ~clk;

    mem_line_arbiter #(.LINE_ADDR_LEN(3), .ADDR_LEN(AW)) dut (
        .clk(clk), .rst(rst),
        .c0_rd_req(c0_rd_req), .c0_wr_req(c0_wr_req), .c0_addr(c0_addr),
        .c0_wr_line(c0_wr_line), .c0_gnt(c0_gnt),
        .c1_rd_req(c1_rd_req), .c1_wr_req(c1_wr_req), .c1_addr(c1_addr),
        .c1_wr_line(c1_wr_line), .c1_gnt(c1_gnt),
        .rd_line(rd_line),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wr_line(mem_wr_line), .mem_gnt(mem_gnt), .mem_rd_line(mem_rd_line),
        .busy(busy)
    );

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [LW-1:0] init_line(logic [AW-1:0] a);
        return {8{23'h5A5A5A, a}};
    endfunction

    task automatic clear_inputs();
        c0_rd_req = 0; c0_wr_req = 0; c0_addr = '0; c0_wr_line = '0;
        c1_rd_req = 0; c1_wr_req = 0; c1_addr = '0; c1_wr_line = '0;
        mem_gnt = 0; mem_rd_line = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_rd = '0;
    endtask

    task automatic pulse_gnt(input logic [LW-1:0] data);
        mem_gnt = 1'b1; mem_rd_line = data;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rd_line = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        #2;
        n_total++; if ({mem_rd_req, mem_wr_req, c0_gnt, c1_gnt, busy} !== 5'b0) $display("FAIL reset_ctrl act=%b exp=00000", {mem_rd_req, mem_wr_req, c0_gnt, c1_gnt, busy}); else n_pass++;
        n_total++; if (rd_line !== '0) $display("FAIL reset_rd_line act=%h exp=0", rd_line); else n_pass++;
        c0_rd_req = 1; c0_addr = 9'h1FF; c0_wr_line = PA; mem_gnt = 1; mem_rd_line = JUNK;
        @(negedge clk); #1;
        n_total++; if ({mem_rd_req, mem_wr_req, c0_gnt, c1_gnt, busy} !== 5'b0 || mem_addr !== '0 || mem_wr_line !== '0 || rd_line !== '0)
            $display("FAIL reset_held act=%b/%h exp=0/0", {mem_rd_req, mem_wr_req, c0_gnt, c1_gnt, busy}, mem_addr); else n_pass++;
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        c0_rd_req = 1; c0_addr = 9'h05; #1;
        n_total++; if (mem_rd_req !== 1'b0 || busy !== 1'b0) $display("FAIL t1_idle_latency act=%b%b exp=00", mem_rd_req, busy); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (mem_rd_req !== 1'b1 || mem_wr_req !== 1'b0 || mem_addr !== 9'h05 || busy !== 1'b1)
            $display("FAIL t1_forward act=%b%b/%h/%b exp=10/005/1", mem_rd_req, mem_wr_req, mem_addr, busy); else n_pass++;
        n_total++; if ({c1_gnt, c0_gnt} !== 2'b00) $display("FAIL t1_no_early_gnt act=%b exp=00", {c1_gnt, c0_gnt}); else n_pass++;
        mem_gnt = 1; mem_rd_line = L1; #1;
        n_total++; if ({c1_gnt, c0_gnt} !== 2'b01) $display("FAIL t1_gnt act=%b exp=01", {c1_gnt, c0_gnt}); else n_pass++;
        @(negedge clk);
        mem_gnt = 0; mem_rd_line = '0; c0_rd_req = 0; #1;
        n_total++; if ({c1_gnt, c0_gnt} !== 2'b00 || busy !== 1'b0) $display("FAIL t1_gnt_one_cycle act=%b/%b exp=00/0", {c1_gnt, c0_gnt}, busy); else n_pass++;
        n_total++; if (rd_line !== L1) $display("FAIL t1_rd_line act=%h exp=%h", rd_line, L1); else n_pass++;
        last_rd = L1;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        do_reset();
        c0_rd_req = 1; c0_addr = 9'h10; c1_rd_req = 1; c1_addr = 9'h20;
        @(negedge clk); #1;
        n_total++; if (mem_rd_req !== 1'b1 || mem_addr !== 9'h10) $display("FAIL t2_first_c0 act=%b/%h exp=1/010", mem_rd_req, mem_addr); else n_pass++;
        mem_gnt = 1; mem_rd_line = L2; #1;
        n_total++; if ({c1_gnt, c0_gnt} !== 2'b01) $display("FAIL t2_gnt_c0 act=%b exp=01", {c1_gnt, c0_gnt}); else n_pass++;
        @(negedge clk);
        mem_gnt = 0; c0_rd_req = 0; #1;
        n_total++; if (mem_rd_req !== 1'b0 || busy !== 1'b0) $display("FAIL t2_gap act=%b%b exp=00", mem_rd_req, busy); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (mem_rd_req !== 1'b0 || busy !== 1'b0) $display("FAIL t2_idle act=%b%b exp=00", mem_rd_req, busy); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (mem_rd_req !== 1'b1 || mem_addr !== 9'h20) $display("FAIL t2_second_c1 act=%b/%h exp=1/020", mem_rd_req, mem_addr); else n_pass++;
        mem_gnt = 1; mem_rd_line = L3; #1;
        n_total++; if ({c1_gnt, c0_gnt} !== 2'b10) $display("FAIL t2_gnt_c1 act=%b exp=10", {c1_gnt, c0_gnt}); else n_pass++;
        @(negedge clk);
        mem_gnt = 0; c1_rd_req = 0; #1;
        n_total++; if (rd_line !== L3) $display("FAIL t2_rd_line act=%h exp=%h", rd_line, L3); else n_pass++;
        @(negedge clk);
        c0_rd_req = 1; c0_addr = 9'h11; c1_rd_req = 1; c1_addr = 9'h21;
        @(negedge clk); #1;
        n_total++; if (mem_rd_req !== 1'b1 || mem_addr !== 9'h11) $display("FAIL t2_third_c0 act=%b/%h exp=1/011", mem_rd_req, mem_addr); else n_pass++;
        pulse_gnt(L2); c0_rd_req = 0;
        @(negedge clk);
        @(negedge clk); #1;
        n_total++; if (mem_addr !== 9'h21) $display("FAIL t2_fourth_c1 act=%h exp=021", mem_addr); else n_pass++;
        pulse_gnt(L3); c1_rd_req = 0;
        last_rd = L3;
        @(negedge clk);
    endtask

    task automatic test_write_then_read();
        c1_wr_req = 1; c1_addr = 9'h1A2; c1_wr_line = PA;
        @(negedge clk); #1;
        n_total++; if ({mem_wr_req, mem_rd_req} !== 2'b10 || mem_addr !== 9'h1A2 || mem_wr_line !== PA)
            $display("FAIL t3_wr_forward act=%b/%h/%h exp=10/1a2/%h", {mem_wr_req, mem_rd_req}, mem_addr, mem_wr_line, PA); else n_pass++;
        mem_gnt = 1; mem_rd_line = JUNK; #1;
        n_total++; if ({c1_gnt, c0_gnt} !== 2'b10) $display("FAIL t3_wr_gnt act=%b exp=10", {c1_gnt, c0_gnt}); else n_pass++;
        @(negedge clk);
        mem_gnt = 0; mem_rd_line = '0;
        c1_wr_req = 0; c1_rd_req = 1; c1_addr = 9'h33; c0_rd_req = 1; c0_addr = 9'h44; #1;
        n_total++; if (rd_line !== last_rd) $display("FAIL t3_wr_keeps_rd_line act=%h exp=%h", rd_line, last_rd); else n_pass++;
        @(negedge clk);
        @(negedge clk); #1;
        n_total++; if (mem_rd_req !== 1'b1 || mem_addr !== 9'h44) $display("FAIL t3_c0_wins act=%b/%h exp=1/044", mem_rd_req, mem_addr); else n_pass++;
        pulse_gnt(L5); c0_rd_req = 0; #1;
        n_total++; if (rd_line !== L5) $display("FAIL t3_c0_rd_line act=%h exp=%h", rd_line, L5); else n_pass++;
        @(negedge clk);
        @(negedge clk); #1;
        n_total++; if (mem_addr !== 9'h33) $display("FAIL t3_c1_next act=%h exp=033", mem_addr); else n_pass++;
        pulse_gnt(L6); c1_rd_req = 0;
        last_rd = L6;
    endtask

    task automatic test_rd_wr_both();
        @(negedge clk);
        c0_rd_req = 1; c0_wr_req = 1; c0_addr = 9'h55; c0_wr_line = PB;
        @(negedge clk); #1;
        n_total++; if ({mem_wr_req, mem_rd_req} !== 2'b10 || mem_wr_line !== PB) $display("FAIL t4_write_wins act=%b exp=10", {mem_wr_req, mem_rd_req}); else n_pass++;
        pulse_gnt(JUNK); c0_rd_req = 0; c0_wr_req = 0; #1;
        n_total++; if (rd_line !== last_rd) $display("FAIL t4_rd_line_kept act=%h exp=%h", rd_line, last_rd); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_abort_and_stray();
        do_reset();
        c0_rd_req = 1; c0_addr = 9'h66;
        @(negedge clk);
        c0_rd_req = 0; #1;
        n_total++; if (mem_rd_req !== 1'b0 || {c1_gnt, c0_gnt} !== 2'b00) $display("FAIL t5_abort_drop act=%b/%b exp=0/00", mem_rd_req, {c1_gnt, c0_gnt}); else n_pass++;
        @(negedge clk);
        mem_gnt = 1; mem_rd_line = JUNK; #1;
        n_total++; if ({c1_gnt, c0_gnt} !== 2'b00 || busy !== 1'b0) $display("FAIL t5_stray_gap act=%b/%b exp=00/0", {c1_gnt, c0_gnt}, busy); else n_pass++;
        @(negedge clk); #1;
        n_total++; if ({c1_gnt, c0_gnt} !== 2'b00) $display("FAIL t5_stray_idle act=%b exp=00", {c1_gnt, c0_gnt}); else n_pass++;
        @(negedge clk);
        mem_gnt = 0; mem_rd_line = '0; #1;
        n_total++; if (rd_line !== '0) $display("FAIL t5_no_capture act=%h exp=0", rd_line); else n_pass++;
        c0_rd_req = 1; c0_addr = 9'h67; c1_rd_req = 1; c1_addr = 9'h77;
        @(negedge clk); #1;
        n_total++; if (mem_addr !== 9'h67) $display("FAIL t5_prio_kept act=%h exp=067", mem_addr); else n_pass++;
        pulse_gnt(L2); c0_rd_req = 0;
        @(negedge clk);
        @(negedge clk);
        pulse_gnt(L8); c1_rd_req = 0;
        last_rd = L8;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        c0_rd_req = 1; c0_addr = 9'h99;
        @(negedge clk); #1;
        n_total++; if (mem_rd_req !== 1'b1 || rd_line !== L8) $display("FAIL t6_pre act=%b/%h exp=1/%h", mem_rd_req, rd_line, L8); else n_pass++;
        rst = 1'b1; #1;
        n_total++; if (mem_rd_req !== 1'b0 || busy !== 1'b0 || rd_line !== '0) $display("FAIL t6_async_abort act=%b%b/%h exp=00/0", mem_rd_req, busy, rd_line); else n_pass++;
        @(negedge clk);
        rst = 1'b0; #1;
        n_total++; if (mem_rd_req !== 1'b0) $display("FAIL t6_post_idle act=%b exp=0", mem_rd_req); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (mem_rd_req !== 1'b1 || mem_addr !== 9'h99) $display("FAIL t6_restart act=%b/%h exp=1/099", mem_rd_req, mem_addr); else n_pass++;
        pulse_gnt(L9); c0_rd_req = 0; #1;
        n_total++; if (rd_line !== L9) $display("FAIL t6_rd_line act=%h exp=%h", rd_line, L9); else n_pass++;
        @(negedge clk);
    endtask

    // Random traffic: clients hold requests until granted, memory answers after 0..3 extra cycles.
    task automatic test_random(input int ncycles);
        logic          pend [2];
        logic          wr   [2];
        logic [AW-1:0] ad   [2];
        logic [LW-1:0] wl   [2];
        logic [1:0]    pend_prev;
        logic          active, active_prev, model_prio, check_rd;
        logic [LW-1:0] exp_rd;
        int            lat, cur, granted_last;
        do_reset();
        mem_arr.delete();
        for (int n = 0; n < 2; n++) begin pend[n] = 0; wr[n] = 0; ad[n] = '0; wl[n] = '0; end
        pend_prev = 2'b00; active_prev = 0; model_prio = 0; check_rd = 0;
        exp_rd = '0; lat = 0; cur = 0; granted_last = -1;
        for (int cyc = 0; cyc < ncycles; cyc++) begin
            @(negedge clk);
            mem_gnt = 0; mem_rd_line = '0;
            if (check_rd) begin
                n_total++; if (rd_line !== exp_rd) $display("FAIL rnd_rd_line cyc=%0d act=%h exp=%h", cyc, rd_line, exp_rd); else n_pass++;
                check_rd = 0;
            end
            for (int n = 0; n < 2; n++) begin
                if (granted_last == n) pend[n] = 0;
                if (!pend[n] && $urandom_range(0, 2) == 0) begin
                    pend[n] = 1; wr[n] = $urandom_range(0, 1);
                    ad[n] = 9'($urandom_range(0, 7)); wl[n] = rand_line();
                end
            end
            granted_last = -1;
            c0_rd_req = pend[0] & ~wr[0]; c0_wr_req = pend[0] & wr[0]; c0_addr = ad[0]; c0_wr_line = wl[0];
            c1_rd_req = pend[1] & ~wr[1]; c1_wr_req = pend[1] & wr[1]; c1_addr = ad[1]; c1_wr_line = wl[1];
            #1;
            active = mem_rd_req | mem_wr_req;
            if (active && !active_prev) begin
                cur = (pend_prev == 2'b11) ? int'(model_prio) : (pend_prev[1] ? 1 : 0);
                lat = $urandom_range(0, 3);
                n_total++;
                if (pend_prev == 2'b00 || mem_addr !== ad[cur] || mem_wr_req !== wr[cur] || (wr[cur] && mem_wr_line !== wl[cur]))
                    $display("FAIL rnd_owner cyc=%0d pend=%b act_addr=%h exp_addr=%h act_wr=%b exp_wr=%b", cyc, pend_prev, mem_addr, ad[cur], mem_wr_req, wr[cur]);
                else n_pass++;
            end
            if (active) begin
                if (lat == 0) begin
                    mem_gnt = 1;
                    if (wr[cur]) mem_arr[ad[cur]] = wl[cur];
                    else begin
                        exp_rd = mem_arr.exists(ad[cur]) ? mem_arr[ad[cur]] : init_line(ad[cur]);
                        mem_rd_line = exp_rd;
                        check_rd = 1;
                    end
                    granted_last = cur;
                    model_prio = (cur == 0);
                    #1;
                    n_total++; if ({c1_gnt, c0_gnt} !== ((cur == 1) ? 2'b10 : 2'b01)) $display("FAIL rnd_gnt cyc=%0d act=%b owner=%0d", cyc, {c1_gnt, c0_gnt}, cur); else n_pass++;
                end else begin
                    lat--;
                end
            end
            active_prev = active;
            pend_prev = {pend[1], pend[0]};
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        last_rd = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_then_read();
        test_rd_wr_both();
        test_abort_and_stray();
        test_reset_mid();
        test_random(600);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
